// File: rtl/orx_sched_pkg.sv
// Shared types and helpers for the ORX feedback-path scheduler.
package orx_sched_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    SETTLE  = 2'd1,
    CAPTURE = 2'd2,
    GAP     = 2'd3
  } state_t;

  localparam int DEF_ANT_NUM    = 8;
  localparam int DEF_SETTLE_CYC = 50;
  localparam int DEF_DWELL_CYC  = 1024;
  localparam int DEF_GAP_CYC    = 8;
  localparam int DEF_CNT_W      = 16;

  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/orx_rr_arb.sv
// Combinational round-robin search: first requester above ptr, wrapping.
module orx_rr_arb
  import orx_sched_pkg::*;
#(
  parameter int ANT_NUM = DEF_ANT_NUM,
  parameter int IW      = idx_w(DEF_ANT_NUM)
) (
  input  logic [ANT_NUM-1:0] req,
  input  logic [IW-1:0]      ptr,
  output logic [IW-1:0]      winner,
  output logic               valid
);

  int idx;

  // NOTE: every variable written in always_comb gets a default first so no latch is inferred.
  always_comb begin
    winner = '0;
    valid  = 1'b0;
    idx    = 0;
    for (int i = 1; i <= ANT_NUM; i++) begin
      idx = (int'(ptr) + i) % ANT_NUM;
      if (!valid && req[idx]) begin
        valid  = 1'b1;
        winner = IW'(idx);
      end
    end
  end

endmodule

// File: rtl/orx_sched.sv
// ORX switch scheduler: arbitrates antennas, settles the switch, opens a capture window.
// Optional macro ORX_ABORT_CNT_EN adds a saturating abort counter with synchronous clear.
module orx_sched
  import orx_sched_pkg::*;
#(
  parameter int ANT_NUM    = DEF_ANT_NUM,
  parameter int SETTLE_CYC = DEF_SETTLE_CYC,
  parameter int DWELL_CYC  = DEF_DWELL_CYC,
  parameter int GAP_CYC    = DEF_GAP_CYC,
  parameter int CNT_W      = DEF_CNT_W,
  localparam int IW        = idx_w(ANT_NUM)
) (
  input  logic               clk_in,
  input  logic               rst,
  input  logic               i_tx_stt,
  input  logic [ANT_NUM-1:0] i_orx_req,
  output logic [IW-1:0]      o_sw_sel,
  output logic               o_sw_on,
  output logic               o_cap_en,
  output logic [ANT_NUM-1:0] o_done_oh,
  output logic               o_abort,
  output logic               o_busy
`ifdef ORX_ABORT_CNT_EN
  ,
  input  logic               i_abort_cnt_clr,
  output logic [15:0]        o_abort_cnt
`endif
);

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [IW-1:0]      ptr_q, ptr_d;
  logic [IW-1:0]      sel_d;
  logic               sw_on_d, cap_d, abort_d, busy_d;
  logic [ANT_NUM-1:0] done_d;
  logic [IW-1:0]      winner;
  logic               win_valid;

  orx_rr_arb #(.ANT_NUM(ANT_NUM), .IW(IW)) u_arb (
    .req    (i_orx_req),
    .ptr    (ptr_q),
    .winner (winner),
    .valid  (win_valid)
  );

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    ptr_d   = ptr_q;
    sel_d   = o_sw_sel;
    sw_on_d = o_sw_on;
    cap_d   = o_cap_en;
    done_d  = '0;
    abort_d = 1'b0;
    unique case (state_q)
      IDLE: begin
        sw_on_d = 1'b0;
        cap_d   = 1'b0;
        if (i_tx_stt && win_valid) begin
          sel_d   = winner;
          sw_on_d = 1'b1;
          cnt_d   = CNT_W'(SETTLE_CYC - 1);
          state_d = SETTLE;
        end
      end
      SETTLE: begin
        if (!i_tx_stt) begin
          sw_on_d = 1'b0;
          cap_d   = 1'b0;
          abort_d = 1'b1;
          state_d = IDLE;
        end else if (cnt_q == '0) begin
          cap_d   = 1'b1;
          cnt_d   = CNT_W'(DWELL_CYC - 1);
          state_d = CAPTURE;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      CAPTURE: begin
        // Completion outranks a same-cycle TX fall: the window was fully captured.
        if (cnt_q == '0) begin
          cap_d            = 1'b0;
          done_d[o_sw_sel] = 1'b1;
          ptr_d            = o_sw_sel;
          if (GAP_CYC == 0) begin
            sw_on_d = 1'b0;
            state_d = IDLE;
          end else begin
            cnt_d   = CNT_W'(GAP_CYC - 1);
            state_d = GAP;
          end
        end else if (!i_tx_stt) begin
          sw_on_d = 1'b0;
          cap_d   = 1'b0;
          abort_d = 1'b1;
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      GAP: begin
        if (cnt_q == '0) begin
          sw_on_d = 1'b0;
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase
    busy_d = (state_d != IDLE);
  end

  // NOTE: rst is synchronous, so it is tested inside the clocked block and not in the sensitivity list.
  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk_in) begin
    if (rst) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      ptr_q     <= IW'(ANT_NUM - 1);
      o_sw_sel  <= '0;
      o_sw_on   <= 1'b0;
      o_cap_en  <= 1'b0;
      o_done_oh <= '0;
      o_abort   <= 1'b0;
      o_busy    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      ptr_q     <= ptr_d;
      o_sw_sel  <= sel_d;
      o_sw_on   <= sw_on_d;
      o_cap_en  <= cap_d;
      o_done_oh <= done_d;
      o_abort   <= abort_d;
      o_busy    <= busy_d;
    end
  end

`ifdef ORX_ABORT_CNT_EN
  always_ff @(posedge clk_in) begin
    if (rst || i_abort_cnt_clr) begin
      o_abort_cnt <= '0;
    end else if (abort_d && (o_abort_cnt != 16'hFFFF)) begin
      o_abort_cnt <= o_abort_cnt + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_orx_sched.sv
// Directed self-checking bench for orx_sched (ANT_NUM=4, SETTLE=4, DWELL=8, GAP=2).
module tb_orx_sched;

  logic       clk_in;
  logic       rst;
  logic       i_tx_stt;
  logic [3:0] i_orx_req;
  logic [1:0] o_sw_sel;
  logic       o_sw_on;
  logic       o_cap_en;
  logic [3:0] o_done_oh;
  logic       o_abort;
  logic       o_busy;
`ifdef ORX_ABORT_CNT_EN
  logic        i_abort_cnt_clr;
  logic [15:0] o_abort_cnt;
`endif

  int checks = 0;
  int errors = 0;

  orx_sched #(
    .ANT_NUM(4), .SETTLE_CYC(4), .DWELL_CYC(8), .GAP_CYC(2), .CNT_W(16)
  ) dut (
    .clk_in    (clk_in),
    .rst       (rst),
    .i_tx_stt  (i_tx_stt),
    .i_orx_req (i_orx_req),
    .o_sw_sel  (o_sw_sel),
    .o_sw_on   (o_sw_on),
    .o_cap_en  (o_cap_en),
    .o_done_oh (o_done_oh),
    .o_abort   (o_abort),
    .o_busy    (o_busy)
`ifdef ORX_ABORT_CNT_EN
    ,
    .i_abort_cnt_clr (i_abort_cnt_clr),
    .o_abort_cnt     (o_abort_cnt)
`endif
  );

  initial clk_in = 1'b0;
  always #5 clk_in = ~clk_in;

  task automatic tick();
    @(posedge clk_in);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Entered just after the grant edge; leaves the bench in IDLE one cycle before the next grant.
  task automatic do_capture(input int sel, input bit drop_mid, input bit tx_fall_last);
    int n;
    check("grant_sw_on", 32'(o_sw_on), 32'd1);
    check("grant_sel", 32'(o_sw_sel), 32'(sel));
    check("grant_busy", 32'(o_busy), 32'd1);
    repeat (3) tick();
    check("settle_cap_low", 32'(o_cap_en), 32'd0);
    tick();
    check("cap_rise", 32'(o_cap_en), 32'd1);
    n = 1;
    for (int k = 1; k <= 7; k++) begin
      tick();
      if (o_cap_en) n++;
      if (drop_mid && k == 2) i_orx_req[sel] = 1'b0;
      if (tx_fall_last && k == 7) i_tx_stt = 1'b0;
    end
    check("cap_len", 32'(n), 32'd8);
    tick();
    check("done_cap_low", 32'(o_cap_en), 32'd0);
    check("done_onehot", 32'(o_done_oh), 32'd1 << sel);
    check("done_no_abort", 32'(o_abort), 32'd0);
    if (!drop_mid) i_orx_req[sel] = 1'b0;
    tick();
    check("gap_done_clear", 32'(o_done_oh), 32'd0);
    check("gap_sw_on", 32'(o_sw_on), 32'd1);
    tick();
    check("idle_sw_off", 32'(o_sw_on), 32'd0);
    check("idle_not_busy", 32'(o_busy), 32'd0);
  endtask

  initial begin
    rst       = 1'b1;
    i_tx_stt  = 1'b0;
    i_orx_req = 4'b0000;
`ifdef ORX_ABORT_CNT_EN
    i_abort_cnt_clr = 1'b0;
`endif
    tick();
    tick();
    rst = 1'b0;
    check("rst_sel", 32'(o_sw_sel), 32'd0);
    check("rst_sw_on", 32'(o_sw_on), 32'd0);
    check("rst_cap", 32'(o_cap_en), 32'd0);
    check("rst_done", 32'(o_done_oh), 32'd0);
    check("rst_abort", 32'(o_abort), 32'd0);
    check("rst_busy", 32'(o_busy), 32'd0);

    // Single requester, basic timing
    i_tx_stt  = 1'b1;
    i_orx_req = 4'b0001;
    tick();
    do_capture(0, 1'b0, 1'b0);

    // All requesting: pointer restarts at 3 after reset, so order is 0,1,2,3
    rst = 1'b1;
    tick();
    rst = 1'b0;
    i_orx_req = 4'b1111;
    for (int a = 0; a < 4; a++) begin
      tick();
      do_capture(a, 1'b0, 1'b0);
    end

    // Requester 1 drops mid-capture; pointer ends at 1
    i_orx_req = 4'b0010;
    tick();
    do_capture(1, 1'b1, 1'b0);

    // Antenna 2 wins over 1 from ptr=1, then TX falls on its third capture cycle
    i_orx_req = 4'b0110;
    tick();
    check("abort_grant_sel", 32'(o_sw_sel), 32'd2);
    repeat (6) tick();
    check("abort_cap_before", 32'(o_cap_en), 32'd1);
    i_tx_stt = 1'b0;
    tick();
    check("abort_cap_low", 32'(o_cap_en), 32'd0);
    check("abort_sw_off", 32'(o_sw_on), 32'd0);
    check("abort_pulse", 32'(o_abort), 32'd1);
    check("abort_no_done", 32'(o_done_oh), 32'd0);
    check("abort_idle", 32'(o_busy), 32'd0);
    tick();
    check("abort_pulse_end", 32'(o_abort), 32'd0);
    i_tx_stt = 1'b1;
    tick();
    do_capture(2, 1'b0, 1'b0);

    // TX falls exactly on the last capture cycle: done wins, GAP finishes normally
    tick();
    do_capture(1, 1'b0, 1'b1);

    // TX low: requests ignored
    i_orx_req = 4'b0110;
    for (int c = 0; c < 6; c++) begin
      tick();
      check("txoff_busy", 32'(o_busy), 32'd0);
      check("txoff_sw_on", 32'(o_sw_on), 32'd0);
    end

    // Reset mid-capture
    i_tx_stt = 1'b1;
    tick();
    check("rstcap_grant_sel", 32'(o_sw_sel), 32'd2);
    repeat (6) tick();
    check("rstcap_in_cap", 32'(o_cap_en), 32'd1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("rstcap_sel", 32'(o_sw_sel), 32'd0);
    check("rstcap_sw_on", 32'(o_sw_on), 32'd0);
    check("rstcap_cap", 32'(o_cap_en), 32'd0);
    check("rstcap_done", 32'(o_done_oh), 32'd0);
    check("rstcap_abort", 32'(o_abort), 32'd0);
    check("rstcap_busy", 32'(o_busy), 32'd0);
`ifdef ORX_ABORT_CNT_EN
    check("rstcap_abort_cnt", 32'(o_abort_cnt), 32'd0);
`endif
    i_orx_req = 4'b1001;
    tick();
    check("ptr_reset_sel", 32'(o_sw_sel), 32'd0);
    check("ptr_reset_sw_on", 32'(o_sw_on), 32'd1);

    // Three forced aborts from SETTLE
    for (int i = 0; i < 3; i++) begin
      i_tx_stt = 1'b0;
      tick();
      check("forced_abort", 32'(o_abort), 32'd1);
      tick();
      if (i < 2) begin
        i_tx_stt = 1'b1;
        tick();
      end
    end
`ifdef ORX_ABORT_CNT_EN
    check("abort_cnt_3", 32'(o_abort_cnt), 32'd3);
    i_abort_cnt_clr = 1'b1;
    tick();
    i_abort_cnt_clr = 1'b0;
    check("abort_cnt_clr", 32'(o_abort_cnt), 32'd0);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
